// File: rtl/xor_pkg.sv
// Shared definitions for the XOR checksum family.
//   state_e    : two-state handshake FSM encoding (ACCUM = collecting words,
//                HOLD = presenting a finished result)
//   len_width  : bit width needed to hold a beat count of 0..max_len
package xor_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // A count saturating at max_len needs to represent max_len+1 distinct values.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/xor_reduce.sv
// Combinational reduction-XOR of a WIDTH-bit word (even parity bit).
//   data   : word to reduce
//   parity : 1 when data has an odd number of set bits
// Kept as its own block so other parity checkers can reuse it; the reduction
// operator lets synthesis build a balanced XOR tree.
module xor_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = ^data;

endmodule

// File: rtl/xor_checksum_stream.sv
// Streaming XOR checksum: folds a packet of WIDTH-bit words (valid/ready
// input, in_last marks the final word) into one registered result carrying
// the XOR of all words, its parity, the saturating beat count and an overflow
// flag. The result is held with valid/ready backpressure; no new words are
// taken while a result is pending.
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid/in_ready        : input word handshake
//   in_data, in_last         : input word and end-of-packet marker
//   out_valid/out_ready      : result handshake
//   out_xor, out_parity      : XOR of the packet, ^out_xor ^ ODD_PARITY
//   out_len, out_overflow    : beats accepted (saturating at MAX_LEN), and
//                              whether the packet exceeded MAX_LEN beats
module xor_checksum_stream
  import xor_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   MAX_LEN    = 16,
  parameter bit   ODD_PARITY = 1'b0,
  localparam int  LW         = len_width(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_xor,
  output logic             out_parity,
  output logic [LW-1:0]    out_len,
  output logic             out_overflow
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q;
  logic [LW-1:0]    cnt_q;
  logic             ovf_q;
  logic [WIDTH-1:0] out_xor_q;
  logic [LW-1:0]    out_len_q;
  logic             out_ovf_q;

  logic             in_fire;
  logic             out_fire;
  logic             cnt_at_max;
  logic [LW-1:0]    cnt_inc;
  logic             xor_parity;

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // A beat arriving while the count already sits at MAX_LEN is the one that
  // overflows; the count itself stays pinned there.
  assign cnt_at_max = (cnt_q == LW'(MAX_LEN));
  assign cnt_inc    = cnt_at_max ? cnt_q : cnt_q + LW'(1);

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACCUM: if (in_fire && in_last) state_d = ST_HOLD;
      ST_HOLD:  if (out_fire)           state_d = ST_ACCUM;
      default:                          state_d = ST_ACCUM;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ACCUM;
    else        state_q <= state_d;
  end

  // NOTE: all datapath registers are reset, because an aborted packet must
  // leave no residue in the accumulator, count or held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_xor_q <= '0;
      out_len_q <= '0;
      out_ovf_q <= 1'b0;
    end else if (in_fire) begin
      if (in_last) begin
        out_xor_q <= acc_q ^ in_data;
        out_len_q <= cnt_inc;
        out_ovf_q <= ovf_q | cnt_at_max;
        acc_q     <= '0;
        cnt_q     <= '0;
        ovf_q     <= 1'b0;
      end else begin
        acc_q <= acc_q ^ in_data;
        cnt_q <= cnt_inc;
        ovf_q <= ovf_q | cnt_at_max;
      end
    end
  end

  // Parity is derived from the held checksum register, so it is as stable as
  // out_xor and has no path from the input side.
  xor_reduce #(.WIDTH(WIDTH)) u_parity (
    .data   (out_xor_q),
    .parity (xor_parity)
  );

  assign out_xor      = out_xor_q;
  assign out_parity   = xor_parity ^ ODD_PARITY;
  assign out_len      = out_len_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_xor_checksum_stream.sv
// Two instances share one stimulus stream: u_dut0 (MAX_LEN=16, even parity)
// and u_dut1 (MAX_LEN=4, odd parity). Expected results come from a per-packet
// word queue folded with plain arithmetic.
module tb_xor_checksum_stream;

  localparam int W   = 8;
  localparam int ML0 = 16;
  localparam int ML1 = 4;
  localparam int LW0 = $clog2(ML0 + 1);
  localparam int LW1 = $clog2(ML1 + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;

  logic           in_ready0, out_valid0, out_parity0, out_overflow0;
  logic [W-1:0]   out_xor0;
  logic [LW0-1:0] out_len0;
  logic           in_ready1, out_valid1, out_parity1, out_overflow1;
  logic [W-1:0]   out_xor1;
  logic [LW1-1:0] out_len1;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] pkt[$];

  always #5 clk = ~clk;

  xor_checksum_stream #(.WIDTH(W), .MAX_LEN(ML0), .ODD_PARITY(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_xor(out_xor0), .out_parity(out_parity0), .out_len(out_len0),
    .out_overflow(out_overflow0)
  );

  xor_checksum_stream #(.WIDTH(W), .MAX_LEN(ML1), .ODD_PARITY(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_xor(out_xor1), .out_parity(out_parity1), .out_len(out_len1),
    .out_overflow(out_overflow1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: fold the recorded packet words.
  function automatic logic [W-1:0] ref_xor();
    logic [W-1:0] r = '0;
    foreach (pkt[i]) r = r ^ pkt[i];
    return r;
  endfunction

  function automatic int ref_len(input int max_len);
    return (pkt.size() > max_len) ? max_len : pkt.size();
  endfunction

  function automatic logic ref_ovf(input int max_len);
    return pkt.size() > max_len;
  endfunction

  function automatic logic ref_par(input logic [W-1:0] x, input logic odd);
    return logic'($countones(x) % 2) ^ odd;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".valid0"}, 32'(out_valid0), 32'd0);
    check({tag, ".ready0"}, 32'(in_ready0),  32'd1);
    check({tag, ".valid1"}, 32'(out_valid1), 32'd0);
    check({tag, ".ready1"}, 32'(in_ready1),  32'd1);
  endtask

  task automatic check_result(input string tag);
    logic [W-1:0] x;
    x = ref_xor();
    check({tag, ".valid0"}, 32'(out_valid0),    32'd1);
    check({tag, ".ready0"}, 32'(in_ready0),     32'd0);
    check({tag, ".xor0"},   32'(out_xor0),      32'(x));
    check({tag, ".par0"},   32'(out_parity0),   32'(ref_par(x, 1'b0)));
    check({tag, ".len0"},   32'(out_len0),      32'(ref_len(ML0)));
    check({tag, ".ovf0"},   32'(out_overflow0), 32'(ref_ovf(ML0)));
    check({tag, ".valid1"}, 32'(out_valid1),    32'd1);
    check({tag, ".ready1"}, 32'(in_ready1),     32'd0);
    check({tag, ".xor1"},   32'(out_xor1),      32'(x));
    check({tag, ".par1"},   32'(out_parity1),   32'(ref_par(x, 1'b1)));
    check({tag, ".len1"},   32'(out_len1),      32'(ref_len(ML1)));
    check({tag, ".ovf1"},   32'(out_overflow1), 32'(ref_ovf(ML1)));
  endtask

  // Drive the words in pkt, optionally with idle gaps during which in_last
  // wiggles with in_valid low (must be ignored).
  task automatic send_pkt(input int max_gap);
    foreach (pkt[i]) begin
      repeat ($urandom_range(max_gap, 0)) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom);
        in_data  = W'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = (i == pkt.size() - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Result must be presented the cycle after the last beat, stay stable while
  // held back (junk input offered meanwhile), then leave after one transfer.
  task automatic take_result(input string tag, input int hold, input bit junk);
    check_result(tag);
    repeat (hold) begin
      out_ready = 1'b0;
      in_valid  = junk;
      in_data   = 8'hFF;
      in_last   = junk;
      @(posedge clk); #1;
      check_result({tag, ".hold"});
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_idle({tag, ".drain"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("rst");
    check("rst.xor0", 32'(out_xor0), 32'h0);
    check("rst.len0", 32'(out_len0), 32'h0);
    check("rst.ovf0", 32'(out_overflow0), 32'h0);
    check("rst.par0", 32'(out_parity0), 32'h0);
    check("rst.par1", 32'(out_parity1), 32'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three-beat packet, consumer ready
    pkt = '{8'h0F, 8'hF0, 8'hAA};
    send_pkt(0);
    check("t2.xor_const", 32'(out_xor0), 32'h55);
    take_result("t2", 0, 1'b0);

    // Single-beat packet: parity 1 even, 0 odd
    pkt = '{8'h01};
    send_pkt(0);
    check("t3.par_even", 32'(out_parity0), 32'h1);
    check("t3.par_odd",  32'(out_parity1), 32'h0);
    take_result("t3", 0, 1'b0);

    // Backpressure with junk offered during HOLD
    pkt = '{8'h3C};
    send_pkt(0);
    take_result("t4", 5, 1'b1);
    pkt = '{8'h81, 8'h18};
    send_pkt(0);
    take_result("t4.next", 0, 1'b0);

    // Overflow: six beats exceed MAX_LEN=4 on u_dut1, then a clean packet
    pkt = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    send_pkt(0);
    check("t5.len1_sat", 32'(out_len1), 32'd4);
    check("t5.ovf1_set", 32'(out_overflow1), 32'd1);
    take_result("t5", 1, 1'b0);
    pkt = '{8'h5A};
    send_pkt(0);
    take_result("t5.next", 0, 1'b0);

    // Exactly MAX_LEN beats on u_dut1: saturated count, no overflow
    pkt = '{8'h11, 8'h22, 8'h44, 8'h88};
    send_pkt(0);
    take_result("t5.exact", 0, 1'b0);

    // Reset mid-packet discards the partial packet
    in_valid = 1'b1; in_data = 8'h12; in_last = 1'b0;
    @(posedge clk); #1;
    in_data = 8'h34;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle("t6.rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("t6.post");
    pkt = '{8'h33};
    send_pkt(0);
    take_result("t6", 0, 1'b0);

    // Reset while a result is held: nothing emitted afterwards
    pkt = '{8'hC3, 8'h7E};
    send_pkt(0);
    check("t6h.valid", 32'(out_valid0), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle("t6h.rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("t6h.post");

    // Randomized packets with gaps, lengths across both MAX_LEN values
    for (int p = 0; p < 30; p++) begin
      pkt.delete();
      for (int k = 0; k < int'($urandom_range(20, 1)); k++)
        pkt.push_back(W'($urandom));
      send_pkt(2);
      take_result($sformatf("rnd%0d", p), $urandom_range(3, 0), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
